multi_channel_packetizer: RTL and testbench
===========================================

Name: multi_channel_packetizer

Overview:
Parametrised successor to the single-channel data packetizer in the detector datapath. It takes NUM_CH processing FIFOs (one per ADC channel), arbitrates round-robin among channels with data, and serialises each selected word into a framed byte packet: sync, channel ID, payload and XOR checksum. The output drives the 8-bit SD-card write FIFO. Adds per-channel enable, backpressure stalling, and packet statistics.

Parameters:
NUM_CH, 4, number of input channels (1..16)
WORD_W, 108, width of one processing-FIFO word in bits
CNT_W, 12, width of each channel's FIFO data count
MIN_COUNT, 1, minimum data count for a channel to request service
SYNC_BYTE, 8'hA5, first byte of every packet

Ports:
clk210_p  in  1  210 MHz system clock; all logic on rising edge
reset_p  in  1  synchronous active-high reset
channel_enable_p  in  NUM_CH  per-channel service enable; bit i = channel i
fifo_ch_dout_p  in  NUM_CH*WORD_W  concatenated FIFO dout; channel i at [i*WORD_W +: WORD_W]
fifo_ch_data_count_p  in  NUM_CH*CNT_W  concatenated data counts; channel i at [i*CNT_W +: CNT_W]
fifo_ch_rd_en_p  out  NUM_CH  one-hot read enable to channel FIFOs
sd_write_fifo_din_p  out  8  byte to SD write FIFO
sd_write_fifo_wr_en_p  out  1  write strobe, one byte per asserted cycle
sd_write_fifo_full_p  in  1  SD write FIFO full
busy_p  out  1  high while a packet is in progress (any state other than IDLE)
current_channel_p  out  4  channel of the current or last packet
packets_sent_p  out  32  count of completed packets, wraps at 2^32

Behaviour:
- Reset values: rd_en=0, din=8'h00, wr_en=0, busy=0, current_channel=0, packets_sent=0. The round-robin pointer resets to NUM_CH-1, so channel 0 has first priority. State resets to IDLE.
- A channel requests service when channel_enable_p[i]=1 and its data count >= MIN_COUNT.
- Input FIFOs are standard-mode (not FWFT): dout is valid on the cycle after rd_en.
- PB = ceil(WORD_W/8), which is 14 by default. The word is zero-extended on the MSB side to PB*8 bits.
- Packet format: SYNC_BYTE, {4'h0, ch[3:0]}, then PB payload bytes MSB-first, then CSUM = XOR of the PB payload bytes only. Default packet length is 17 bytes.
- States:
  - IDLE: if any channel requests, grant the first requesting channel searching from pointer+1 modulo NUM_CH. Latch the grant into current_channel and go to READ. Otherwise stay in IDLE.
  - READ: rd_en[grant]=1 for exactly one cycle, then go to WAIT.
  - WAIT: capture the granted dout slice into the shift register and clear the checksum accumulator, then go to SYNC.
  - SYNC / HDR / PAYLOAD / CSUM: emit one byte per cycle in which full_p=0. PAYLOAD uses a byte counter 0..PB-1; each emitted payload byte is XORed into the accumulator.
  - After CSUM is emitted: packets_sent+1, pointer=grant, return to IDLE.
- Write handshake:
  - wr_en is combinational: (state is SYNC, HDR, PAYLOAD or CSUM) AND !full_p AND !reset_p.
  - din is combinational from the state, shift register and accumulator. It is stable while stalled.
  - When full_p=1, wr_en=0, and the state and byte counter hold. No byte is lost or duplicated.
- Minimum packet period with no backpressure: 1 + 1 + 1 + (PB+3) cycles, which is 20 cycles by default.
- Exactly one FIFO read per packet. No rd_en is ever asserted outside READ.
- Enable deasserted, or count dropping, after grant: the packet still completes. The change is only sampled in IDLE.
- Only one channel requesting: it is served back-to-back. The round-robin pointer has no effect.
- reset_p asserted mid-packet: wr_en and rd_en are forced low in that cycle. The packet is abandoned and the captured word is discarded. Everything returns to its reset value on the next edge.
- packets_sent wraps from 32'hFFFFFFFF to 0.

Test Plan:
1. Single word: ch0 count=1 with dout=108'h0 except the low byte 0x5A. Expect wr_en for 17 bytes: A5, 00, thirteen 00, 5A, then CSUM 5A. rd_en[0] high for exactly 1 cycle; packets_sent=1; 20 cycles total.
2. Round-robin: all 4 channels enabled with count=3 each. Expect channel order 0,1,2,3,0,1,2,3,0,1,2,3. packets_sent=12, and each channel receives exactly 3 rd_en pulses.
3. Backpressure: during ch2 payload byte 5, hold full_p=1 for 7 cycles. Expect wr_en=0 and din stable for those 7 cycles. The byte stream is identical to the unstalled reference and the packet ends 7 cycles later.
4. Enable masking: channel_enable=4'b1010 with all counts=2. Expect service only on channels 1 and 3, alternating 1,3,1,3. Channels 0 and 2 never see rd_en.
5. Reset mid-packet: assert reset_p at HDR of a ch1 packet. Expect wr_en=0 in that cycle, all outputs at reset values afterward, and the next packet sourced from ch0 if it is requesting.
6. Checksum: payload bytes 01,02,...,0E on ch3. Expect header byte 03 and CSUM=8'h0F.

Source files
------------

// File: rtl/multi_channel_packetizer_if.sv
// ---------------------------------------------------------------------------
// multi_channel_packetizer_if
// Byte-wide write port toward the SD-card write FIFO.
//   sd_write_fifo_din_p    : byte to write (driven by the packetizer)
//   sd_write_fifo_wr_en_p  : write strobe, one byte per asserted cycle
//   sd_write_fifo_full_p   : FIFO full, stalls the packetizer
// master = packetizer side, slave = FIFO side.
// ---------------------------------------------------------------------------
interface multi_channel_packetizer_if;
    logic [7:0] sd_write_fifo_din_p;
    logic       sd_write_fifo_wr_en_p;
    logic       sd_write_fifo_full_p;

    modport master (
        output sd_write_fifo_din_p,
        output sd_write_fifo_wr_en_p,
        input  sd_write_fifo_full_p
    );

    modport slave (
        input  sd_write_fifo_din_p,
        input  sd_write_fifo_wr_en_p,
        output sd_write_fifo_full_p
    );
endinterface

// File: rtl/multi_channel_packetizer.sv
// ---------------------------------------------------------------------------
// multi_channel_packetizer
// Round-robin arbiter over NUM_CH standard-mode processing FIFOs. Each granted
// word is read once and serialised as a byte packet:
//   SYNC_BYTE, {4'h0, ch}, PB payload bytes (MSB first), XOR of payload bytes.
// Ports:
//   clk210_p              : system clock, rising edge
//   reset_p               : synchronous active-high reset
//   channel_enable_p      : per-channel service enable
//   fifo_ch_dout_p        : concatenated channel FIFO data (ch i at i*WORD_W)
//   fifo_ch_data_count_p  : concatenated channel FIFO counts (ch i at i*CNT_W)
//   fifo_ch_rd_en_p       : one-hot channel FIFO read enable
//   sd_if                 : byte write port to the SD write FIFO
//   busy_p                : packet in progress (state not IDLE)
//   current_channel_p     : channel of the current or last packet
//   packets_sent_p        : completed packet count, wraps at 2^32
// ---------------------------------------------------------------------------
module multi_channel_packetizer #(
    parameter int         NUM_CH    = 4,
    parameter int         WORD_W    = 108,
    parameter int         CNT_W     = 12,
    parameter int         MIN_COUNT = 1,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                      clk210_p,
    input  logic                      reset_p,
    input  logic [NUM_CH-1:0]         channel_enable_p,
    input  logic [NUM_CH*WORD_W-1:0]  fifo_ch_dout_p,
    input  logic [NUM_CH*CNT_W-1:0]   fifo_ch_data_count_p,
    output logic [NUM_CH-1:0]         fifo_ch_rd_en_p,
    multi_channel_packetizer_if.master sd_if,
    output logic                      busy_p,
    output logic [3:0]                current_channel_p,
    output logic [31:0]               packets_sent_p
);

    localparam int PB   = (WORD_W + 7) / 8;
    localparam int SH_W = PB * 8;
    localparam int BC_W = (PB > 1) ? $clog2(PB) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SYNC,
        ST_HDR,
        ST_PAYLOAD,
        ST_CSUM
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        ptr_q, ptr_d;
    logic [3:0]        cur_ch_q, cur_ch_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic [7:0]        csum_q, csum_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [31:0]       packets_q, packets_d;

    logic [15:0]       req_pad_s;
    logic [3:0]        grant_s;
    logic              grant_found_s;
    logic [4:0]        cand_s;
    logic [WORD_W-1:0] sel_word_s;
    logic [NUM_CH-1:0] rd_en_s;
    logic [7:0]        din_s;
    logic              emit_s;
    logic              wr_en_s;
    logic              full_s;

    assign full_s = sd_if.sd_write_fifo_full_p;

    // Request vector, padded to 16 so a 4-bit channel index always fits.
    always_comb begin
        req_pad_s = 16'h0000;
        for (int i = 0; i < NUM_CH; i++) begin
            req_pad_s[i] = channel_enable_p[i] &&
                           (fifo_ch_data_count_p[i*CNT_W +: CNT_W] >= CNT_W'(MIN_COUNT));
        end
    end

    // Round-robin search: first requester starting at ptr+1, wrapping at NUM_CH.
    always_comb begin
        grant_found_s = 1'b0;
        grant_s       = ptr_q;
        cand_s        = 5'd0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_s = {1'b0, ptr_q} + 5'(k);
            if (cand_s >= 5'(NUM_CH)) begin
                cand_s = cand_s - 5'(NUM_CH);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_found_s && req_pad_s[cand_s[3:0]]) begin
                grant_found_s = 1'b1;
                grant_s       = cand_s[3:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Data mux for the granted channel; valid in WAIT (cycle after the read).
    always_comb begin
        sel_word_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_word_s = (4'(i) == cur_ch_q) ? fifo_ch_dout_p[i*WORD_W +: WORD_W] : sel_word_s;
        end
    end

    // One-hot read strobe, only in READ and never while reset is asserted.
    always_comb begin
        rd_en_s = '0;
        if ((state_q == ST_READ) && !reset_p) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rd_en_s[i] = (4'(i) == cur_ch_q);
            end
        end else begin
            rd_en_s = '0;
        end
    end

    // Next-state and byte-output logic; every emitting state holds while full.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_ch_d   = cur_ch_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        byte_cnt_d = byte_cnt_q;
        packets_d  = packets_q;
        din_s      = 8'h00;
        emit_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    cur_ch_d = grant_s;
                    state_d  = ST_READ;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Zero-extend the word on the MSB side to whole bytes.
                shift_d                = '0;
                shift_d[WORD_W-1:0]    = sel_word_s;
                csum_d                 = 8'h00;
                byte_cnt_d             = '0;
                state_d                = ST_SYNC;
            end
            ST_SYNC: begin
                din_s  = SYNC_BYTE;
                emit_s = 1'b1;
                if (!full_s) begin
                    state_d = ST_HDR;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_HDR: begin
                din_s  = {4'h0, cur_ch_q};
                emit_s = 1'b1;
                if (!full_s) begin
                    state_d = ST_PAYLOAD;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                din_s  = shift_q[SH_W-1 -: 8];
                emit_s = 1'b1;
                if (!full_s) begin
                    shift_d = shift_q << 8;
                    csum_d  = csum_q ^ din_s;
                    if (byte_cnt_q == BC_W'(PB - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = ST_CSUM;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_CSUM: begin
                din_s  = csum_q;
                emit_s = 1'b1;
                if (!full_s) begin
                    packets_d = packets_q + 32'd1;
                    ptr_d     = cur_ch_q;
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_CSUM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_en_s = emit_s && !full_s && !reset_p;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 4'(NUM_CH - 1);
            cur_ch_q   <= 4'h0;
            shift_q    <= '0;
            csum_q     <= 8'h00;
            byte_cnt_q <= '0;
            packets_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_ch_q   <= cur_ch_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            byte_cnt_q <= byte_cnt_d;
            packets_q  <= packets_d;
        end
    end

    assign fifo_ch_rd_en_p             = rd_en_s;
    assign sd_if.sd_write_fifo_din_p   = din_s;
    assign sd_if.sd_write_fifo_wr_en_p = wr_en_s;
    assign busy_p                      = (state_q != ST_IDLE);
    assign current_channel_p           = cur_ch_q;
    assign packets_sent_p              = packets_q;

endmodule

// File: tb/tb_multi_channel_packetizer.sv
// ---------------------------------------------------------------------------
// tb_multi_channel_packetizer
// Directed bench: channel FIFO models feed the packetizer, a negedge monitor
// logs written bytes and read strobes, and each test task checks its scenario.
// ---------------------------------------------------------------------------
module tb_multi_channel_packetizer;

    localparam int NUM_CH = 4;
    localparam int WORD_W = 108;
    localparam int CNT_W  = 12;

    logic                      clk = 1'b0;
    logic                      reset_p;
    logic [NUM_CH-1:0]         en;
    logic [NUM_CH*WORD_W-1:0]  dout;
    logic [NUM_CH*CNT_W-1:0]   cnt;
    logic [NUM_CH-1:0]         rd_en;
    logic                      busy;
    logic [3:0]                cur_ch;
    logic [31:0]               pkts;

    multi_channel_packetizer_if sd_if();

    multi_channel_packetizer #(
        .NUM_CH(NUM_CH), .WORD_W(WORD_W), .CNT_W(CNT_W), .MIN_COUNT(1), .SYNC_BYTE(8'hA5)
    ) u_dut (
        .clk210_p             (clk),
        .reset_p              (reset_p),
        .channel_enable_p     (en),
        .fifo_ch_dout_p       (dout),
        .fifo_ch_data_count_p (cnt),
        .fifo_ch_rd_en_p      (rd_en),
        .sd_if                (sd_if),
        .busy_p               (busy),
        .current_channel_p    (cur_ch),
        .packets_sent_p       (pkts)
    );

    always #5 clk = ~clk;

    // Standard-mode FIFO models: dout updates the cycle after rd_en.
    logic [WORD_W-1:0] mem [NUM_CH][64];
    int                wp [NUM_CH];
    int                rp [NUM_CH];
    logic [WORD_W-1:0] dout_r [NUM_CH];

    always @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_en[i]) begin
                dout_r[i] <= mem[i][rp[i] % 64];
                rp[i]     <= rp[i] + 1;
            end
        end
    end

    always_comb begin
        dout = '0;
        cnt  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            dout[i*WORD_W +: WORD_W] = dout_r[i];
            cnt[i*CNT_W +: CNT_W]    = CNT_W'(wp[i] - rp[i]);
        end
    end

    // Monitor
    logic [7:0] bytes_q [$];
    logic [7:0] exp_q [$];
    int         rd_log [$];
    int         rd_time [$];
    int         cyc = 0;
    int         busy_cnt = 0;
    int         checks = 0;
    int         passes = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sd_if.sd_write_fifo_wr_en_p) bytes_q.push_back(sd_if.sd_write_fifo_din_p);
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_en[i]) begin
                rd_log.push_back(i);
                rd_time.push_back(cyc);
            end
        end
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    // Reference packet builder.
    function automatic void add_pkt(input logic [3:0] ch, input logic [WORD_W-1:0] w);
        logic [111:0] x;
        logic [7:0]   b;
        logic [7:0]   cs;
        x  = {4'h0, w};
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back({4'h0, ch});
        for (int i = 13; i >= 0; i--) begin
            b  = x[i*8 +: 8];
            cs = cs ^ b;
            exp_q.push_back(b);
        end
        exp_q.push_back(cs);
    endfunction

    // Index of first byte differing from the reference, -1 when identical.
    function automatic int first_diff();
        if (bytes_q.size() != exp_q.size()) return 9999;
        for (int i = 0; i < bytes_q.size(); i++) begin
            if (bytes_q[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    function automatic int rd_count(input int ch);
        int n;
        n = 0;
        foreach (rd_log[i]) if (rd_log[i] == ch) n++;
        return n;
    endfunction

    task automatic load(input int ch, input logic [WORD_W-1:0] w);
        mem[ch][wp[ch] % 64] = w;
        wp[ch] = wp[ch] + 1;
    endtask

    task automatic do_reset();
        reset_p = 1'b1;
        en = '0;
        sd_if.sd_write_fifo_full_p = 1'b0;
        for (int i = 0; i < NUM_CH; i++) wp[i] = rp[i];
        repeat (2) @(posedge clk);
        #1 reset_p = 1'b0;
        bytes_q.delete(); exp_q.delete(); rd_log.delete(); rd_time.delete();
        busy_cnt = 0;
    endtask

    task automatic wait_pkts(input logic [31:0] tgt, input int budget);
        for (int c = 0; c < budget && pkts != tgt; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        en = '0;
        sd_if.sd_write_fifo_full_p = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (rd_en !== 4'b0000) $display("FAIL reset_rd_en: got %b expected 0000", rd_en); else passes++;
        checks++; if (sd_if.sd_write_fifo_din_p !== 8'h00) $display("FAIL reset_din: got %h expected 00", sd_if.sd_write_fifo_din_p); else passes++;
        checks++; if (sd_if.sd_write_fifo_wr_en_p !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", sd_if.sd_write_fifo_wr_en_p); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (cur_ch !== 4'h0) $display("FAIL reset_cur_ch: got %h expected 0", cur_ch); else passes++;
        checks++; if (pkts !== 32'd0) $display("FAIL reset_pkts: got %0d expected 0", pkts); else passes++;
        @(posedge clk);
        #1 reset_p = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL idle_no_req_busy: got %b expected 0", busy); else passes++;
    endtask

    task automatic test_single_word();
        logic [7:0] e [17];
        int bad;
        do_reset();
        e = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h5A};
        load(0, 108'h5A);
        en = 4'b0001;
        wait_pkts(32'd1, 60);
        checks++; if (pkts !== 32'd1) $display("FAIL single_pkts: got %0d expected 1", pkts); else passes++;
        bad = -1;
        if (bytes_q.size() != 17) bad = 9999;
        else for (int i = 16; i >= 0; i--) if (bytes_q[i] !== e[i]) bad = i;
        checks++; if (bad != -1) $display("FAIL single_bytes: first bad index %0d of %0d bytes, expected 17 bytes", bad, bytes_q.size()); else passes++;
        checks++; if (rd_log.size() != 1 || rd_log[0] != 0) $display("FAIL single_rd_en: got %0d pulses expected 1 on ch0", rd_log.size()); else passes++;
        checks++; if (busy_cnt != 19) $display("FAIL single_busy_cycles: got %0d expected 19 (20-cycle period)", busy_cnt); else passes++;
    endtask

    task automatic test_round_robin();
        int bad;
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int ch = 0; ch < 4; ch++)
                load(ch, {8'(ch*16 + k), 100'h0123456789ABCDEF012345678});
        for (int k = 0; k < 3; k++)
            for (int ch = 0; ch < 4; ch++)
                add_pkt(4'(ch), {8'(ch*16 + k), 100'h0123456789ABCDEF012345678});
        en = 4'b1111;
        wait_pkts(32'd12, 300);
        checks++; if (pkts !== 32'd12) $display("FAIL rr_pkts: got %0d expected 12", pkts); else passes++;
        bad = (rd_log.size() != 12) ? 99 : -1;
        if (bad == -1) for (int i = 0; i < 12; i++) if (rd_log[i] != i % 4 && bad == -1) bad = i;
        checks++; if (bad != -1) $display("FAIL rr_order: first bad position %0d (log size %0d), expected 0,1,2,3 repeating", bad, rd_log.size()); else passes++;
        for (int ch = 0; ch < 4; ch++) begin
            checks++; if (rd_count(ch) != 3) $display("FAIL rr_rd_count_ch%0d: got %0d expected 3", ch, rd_count(ch)); else passes++;
        end
        bad = first_diff();
        checks++; if (bad != -1) $display("FAIL rr_bytes: first bad index %0d, got %0d bytes expected 204", bad, bytes_q.size()); else passes++;
        bad = (rd_time.size() != 12) ? 99 : -1;
        if (bad == -1) for (int i = 1; i < 12; i++) if (rd_time[i] - rd_time[i-1] != 20 && bad == -1) bad = i;
        checks++; if (bad != -1) $display("FAIL rr_period: packet %0d not 20 cycles after previous", bad); else passes++;
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        load(2, 108'hFEDCBA9876543210FEDCBA98765);
        add_pkt(4'd2, 108'hFEDCBA9876543210FEDCBA98765);
        en = 4'b0100;
        for (int c = 0; c < 60 && bytes_q.size() != 7; c++) begin
            @(posedge clk);
            #1;
        end
        checks++; if (bytes_q.size() != 7) $display("FAIL bp_reach_byte5: got %0d bytes expected 7", bytes_q.size()); else passes++;
        sd_if.sd_write_fifo_full_p = 1'b1;
        for (int s = 0; s < 7; s++) begin
            @(negedge clk);
            checks++; if (sd_if.sd_write_fifo_wr_en_p !== 1'b0) $display("FAIL bp_wr_en_stall%0d: got %b expected 0", s, sd_if.sd_write_fifo_wr_en_p); else passes++;
            checks++; if (sd_if.sd_write_fifo_din_p !== 8'h65) $display("FAIL bp_din_stall%0d: got %h expected 65", s, sd_if.sd_write_fifo_din_p); else passes++;
            @(posedge clk);
            #1;
        end
        sd_if.sd_write_fifo_full_p = 1'b0;
        wait_pkts(32'd1, 60);
        bad = first_diff();
        checks++; if (bad != -1) $display("FAIL bp_bytes: first bad index %0d, got %0d bytes expected 17", bad, bytes_q.size()); else passes++;
        checks++; if (busy_cnt != 26) $display("FAIL bp_busy_cycles: got %0d expected 26", busy_cnt); else passes++;
    endtask

    task automatic test_enable_mask();
        int bad;
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int ch = 0; ch < 4; ch++)
                load(ch, {8'(ch*16 + k + 8), 100'h0FEDCBA9876543210FEDCBA98});
        add_pkt(4'd1, {8'(16 + 8), 100'h0FEDCBA9876543210FEDCBA98});
        add_pkt(4'd3, {8'(48 + 8), 100'h0FEDCBA9876543210FEDCBA98});
        add_pkt(4'd1, {8'(16 + 9), 100'h0FEDCBA9876543210FEDCBA98});
        add_pkt(4'd3, {8'(48 + 9), 100'h0FEDCBA9876543210FEDCBA98});
        en = 4'b1010;
        wait_pkts(32'd4, 150);
        repeat (40) @(posedge clk);
        #1;
        checks++; if (pkts !== 32'd4) $display("FAIL mask_pkts: got %0d expected 4", pkts); else passes++;
        bad = (rd_log.size() != 4) ? 99 : -1;
        if (bad == -1) for (int i = 0; i < 4; i++) if (rd_log[i] != ((i % 2 == 0) ? 1 : 3) && bad == -1) bad = i;
        checks++; if (bad != -1) $display("FAIL mask_order: first bad position %0d (log size %0d), expected 1,3,1,3", bad, rd_log.size()); else passes++;
        checks++; if (rd_count(0) + rd_count(2) != 0) $display("FAIL mask_disabled_rd: got %0d reads on ch0/ch2 expected 0", rd_count(0) + rd_count(2)); else passes++;
        bad = first_diff();
        checks++; if (bad != -1) $display("FAIL mask_bytes: first bad index %0d, got %0d bytes expected 68", bad, bytes_q.size()); else passes++;
    endtask

    task automatic test_reset_mid_packet();
        int bad;
        do_reset();
        load(1, 108'h111);
        load(1, 108'h222);
        en = 4'b0010;
        for (int c = 0; c < 60 && bytes_q.size() != 1; c++) begin
            @(posedge clk);
            #1;
        end
        load(0, 108'h333);
        en = 4'b0011;
        reset_p = 1'b1;
        @(negedge clk);
        checks++; if (sd_if.sd_write_fifo_wr_en_p !== 1'b0) $display("FAIL rst_mid_wr_en: got %b expected 0", sd_if.sd_write_fifo_wr_en_p); else passes++;
        checks++; if (rd_en !== 4'b0000) $display("FAIL rst_mid_rd_en: got %b expected 0000", rd_en); else passes++;
        @(posedge clk);
        #1 reset_p = 1'b0;
        checks++; if (busy !== 1'b0 || pkts !== 32'd0 || cur_ch !== 4'h0 || sd_if.sd_write_fifo_din_p !== 8'h00)
            $display("FAIL rst_mid_outputs: got busy=%b pkts=%0d ch=%h din=%h expected 0,0,0,00", busy, pkts, cur_ch, sd_if.sd_write_fifo_din_p);
        else passes++;
        checks++; if (bytes_q.size() != 1) $display("FAIL rst_mid_byte_count: got %0d bytes expected 1 (sync only)", bytes_q.size()); else passes++;
        bytes_q.delete(); rd_log.delete();
        add_pkt(4'd0, 108'h333);
        add_pkt(4'd1, 108'h222);
        wait_pkts(32'd2, 100);
        checks++; if (rd_log.size() != 2 || rd_log[0] != 0 || rd_log[1] != 1) $display("FAIL rst_mid_order: got %0d reads, expected ch0 then ch1", rd_log.size()); else passes++;
        bad = first_diff();
        checks++; if (bad != -1) $display("FAIL rst_mid_bytes: first bad index %0d, got %0d bytes expected 34", bad, bytes_q.size()); else passes++;
    endtask

    task automatic test_checksum();
        int bad;
        do_reset();
        load(3, 108'h102030405060708090A0B0C0D0E);
        en = 4'b1000;
        wait_pkts(32'd1, 60);
        checks++; if (bytes_q.size() != 17) $display("FAIL csum_len: got %0d expected 17", bytes_q.size()); else passes++;
        checks++; if (bytes_q.size() != 17 || bytes_q[1] !== 8'h03) $display("FAIL csum_hdr: got %h expected 03", (bytes_q.size() > 1) ? bytes_q[1] : 8'hxx); else passes++;
        checks++; if (bytes_q.size() != 17 || bytes_q[16] !== 8'h0F) $display("FAIL csum_value: got %h expected 0F", (bytes_q.size() == 17) ? bytes_q[16] : 8'hxx); else passes++;
        bad = (bytes_q.size() != 17) ? 99 : -1;
        if (bad == -1) for (int i = 2; i < 16; i++) if (bytes_q[i] !== 8'(i - 1) && bad == -1) bad = i;
        checks++; if (bad != -1) $display("FAIL csum_payload: first bad index %0d, expected 01..0E", bad); else passes++;
        checks++; if (cur_ch !== 4'h3) $display("FAIL csum_cur_ch: got %h expected 3", cur_ch); else passes++;
    endtask

    initial begin
        reset_p = 1'b1;
        en = '0;
        sd_if.sd_write_fifo_full_p = 1'b0;
        test_reset();
        test_single_word();
        test_round_robin();
        test_backpressure();
        test_enable_mask();
        test_reset_mid_packet();
        test_checksum();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
